// File: rtl/adc_frame_packer.sv
// Packs a snapshot of up to 16 ADC channel words into a framed 16-bit valid/ready stream.
// Optional checksum trailer word enabled by defining PACKER_CHECKSUM_EN.
module adc_frame_packer #(
    parameter int          N_CH     = 16,
    parameter logic [15:0] HDR_WORD = 16'hA5A5
) (
    input  logic                 CLK_20M,
    input  logic                 RESET,
    input  logic [16*N_CH-1:0]   CH_DATA,
    input  logic [N_CH-1:0]      CH_MASK,
    input  logic                 SAMPLE_STB,
    output logic [15:0]          OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 OUT_SOF,
    output logic                 OUT_EOF,
    output logic                 BUSY,
    output logic [15:0]          DROP_CNT
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_SEQ  = 3'd2,
`ifdef PACKER_CHECKSUM_EN
        ST_CSUM = 3'd4,
`endif
        ST_DATA = 3'd3
    } state_t;

    state_t                 state_r;
    logic [15:0]            out_data_r;
    logic                   out_valid_r;
    logic                   out_sof_r;
    logic                   out_eof_r;
    logic                   busy_r;
    logic [15:0]            drop_cnt_r;
    logic [15:0]            seq_r;
    logic [N_CH-1:0][15:0]  data_buf_r;
    logic [N_CH-1:0]        mask_rem_r;
`ifdef PACKER_CHECKSUM_EN
    logic [15:0]            csum_r;
`endif

    logic [3:0]             first_idx_s;
    logic                   any_rem_s;
    logic [N_CH-1:0]        rem_after_s;
    logic                   last_ch_s;
    logic [15:0]            ch_word_s;
    logic                   xfer_s;
    logic                   frame_done_s;
    logic                   start_s;

    // Lowest remaining mask bit selects the next channel word.
    always_comb begin
        first_idx_s = 4'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            first_idx_s = mask_rem_r[i] ? 4'(i) : first_idx_s;
        end
        any_rem_s                = |mask_rem_r;
        rem_after_s              = mask_rem_r;
        rem_after_s[first_idx_s] = 1'b0;
        last_ch_s                = (rem_after_s == {N_CH{1'b0}});
        ch_word_s                = data_buf_r[first_idx_s];
    end

    assign xfer_s       = out_valid_r & OUT_READY;
    assign frame_done_s = xfer_s & out_eof_r;
    // A strobe coinciding with the EOF transfer starts the next frame back-to-back.
    assign start_s      = SAMPLE_STB & ((state_r == ST_IDLE) | frame_done_s);

    // Frame sequencer with registered stream outputs, drop counter and sequence number.
    always_ff @(posedge CLK_20M) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            out_data_r  <= 16'h0000;
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_eof_r   <= 1'b0;
            busy_r      <= 1'b0;
            drop_cnt_r  <= 16'h0000;
            seq_r       <= 16'h0000;
            data_buf_r  <= {N_CH{16'h0000}};
            mask_rem_r  <= {N_CH{1'b0}};
`ifdef PACKER_CHECKSUM_EN
            csum_r      <= 16'h0000;
`endif
        end else begin
            if (frame_done_s) begin
                seq_r <= seq_r + 16'd1;
            end
            if (SAMPLE_STB && busy_r && !frame_done_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end

            if (start_s) begin
                data_buf_r  <= CH_DATA;
                mask_rem_r  <= CH_MASK;
                out_data_r  <= HDR_WORD;
                out_valid_r <= 1'b1;
                out_sof_r   <= 1'b1;
                out_eof_r   <= 1'b0;
                busy_r      <= 1'b1;
                state_r     <= ST_HDR;
`ifdef PACKER_CHECKSUM_EN
                csum_r      <= HDR_WORD;
`endif
            end else if (xfer_s) begin
                case (state_r)
                    ST_HDR: begin
                        // The sequence word is emitted after the header transfer, so a
                        // back-to-back frame already sees the incremented value.
                        out_data_r <= seq_r;
                        out_sof_r  <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
                        out_eof_r  <= 1'b0;
                        csum_r     <= csum_r ^ seq_r;
`else
                        out_eof_r  <= ~any_rem_s;
`endif
                        state_r    <= ST_SEQ;
                    end
                    ST_SEQ, ST_DATA: begin
                        if (out_eof_r) begin
                            out_valid_r <= 1'b0;
                            out_sof_r   <= 1'b0;
                            out_eof_r   <= 1'b0;
                            busy_r      <= 1'b0;
                            state_r     <= ST_IDLE;
                        end else if (any_rem_s) begin
                            out_data_r <= ch_word_s;
                            mask_rem_r <= rem_after_s;
`ifdef PACKER_CHECKSUM_EN
                            out_eof_r  <= 1'b0;
                            csum_r     <= csum_r ^ ch_word_s;
`else
                            out_eof_r  <= last_ch_s;
`endif
                            state_r    <= ST_DATA;
                        end else begin
`ifdef PACKER_CHECKSUM_EN
                            out_data_r <= csum_r;
                            out_eof_r  <= 1'b1;
                            state_r    <= ST_CSUM;
`else
                            out_valid_r <= 1'b0;
                            out_eof_r   <= 1'b0;
                            busy_r      <= 1'b0;
                            state_r     <= ST_IDLE;
`endif
                        end
                    end
                    default: begin
                        out_valid_r <= 1'b0;
                        out_sof_r   <= 1'b0;
                        out_eof_r   <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign OUT_DATA  = out_data_r;
    assign OUT_VALID = out_valid_r;
    assign OUT_SOF   = out_sof_r;
    assign OUT_EOF   = out_eof_r;
    assign BUSY      = busy_r;
    assign DROP_CNT  = drop_cnt_r;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer: expected words queued at strobe time, popped on transfers.
module tb_adc_frame_packer;

    logic          CLK_20M = 1'b0;
    logic          RESET;
    logic [255:0]  CH_DATA;
    logic [15:0]   CH_MASK;
    logic          SAMPLE_STB;
    logic [15:0]   OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          OUT_SOF;
    logic          OUT_EOF;
    logic          BUSY;
    logic [15:0]   DROP_CNT;

    int            checks = 0;
    int            errors = 0;
    logic [17:0]   exp_q[$];
    logic [15:0]   exp_seq = 16'h0000;
    logic          prev_stall = 1'b0;
    logic [17:0]   prev_word = 18'h00000;

    adc_frame_packer dut (
        .CLK_20M   (CLK_20M),
        .RESET     (RESET),
        .CH_DATA   (CH_DATA),
        .CH_MASK   (CH_MASK),
        .SAMPLE_STB(SAMPLE_STB),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_SOF   (OUT_SOF),
        .OUT_EOF   (OUT_EOF),
        .BUSY      (BUSY),
        .DROP_CNT  (DROP_CNT)
    );

    always #5 CLK_20M = ~CLK_20M;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [15:0] base);
        for (int k = 0; k < 16; k++) CH_DATA[16*k +: 16] = base + 16'(k);
    endtask

    // Expected frame: {sof, eof, data} per word.
    task automatic push_frame(input logic [15:0] mask, input logic [15:0] base, input logic [15:0] seq);
        logic [17:0] w[$];
        logic [15:0] x;
        w.push_back({2'b10, 16'hA5A5});
        w.push_back({2'b00, seq});
        for (int k = 0; k < 16; k++)
            if (mask[k]) w.push_back({2'b00, base + 16'(k)});
`ifdef PACKER_CHECKSUM_EN
        x = 16'h0000;
        foreach (w[i]) x = x ^ w[i][15:0];
        w.push_back({2'b00, x});
`endif
        w[w.size()-1][16] = 1'b1;
        foreach (w[i]) exp_q.push_back(w[i]);
    endtask

    task automatic do_strobe();
        @(posedge CLK_20M); #1 SAMPLE_STB = 1'b1;
        @(posedge CLK_20M); #1 SAMPLE_STB = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || OUT_VALID) && n < 400) begin
            @(posedge CLK_20M); #1;
            if (toggle) OUT_READY = ~OUT_READY;
            @(negedge CLK_20M);
            n++;
        end
        check_eq("drain_timeout", 32'(n < 400), 32'd1);
        OUT_READY = 1'b1;
    endtask

    // Output monitor: scoreboard compare on transfers, hold check on stalls.
    always @(negedge CLK_20M) begin
        if (prev_stall) begin
            check_eq("hold_valid", 32'(OUT_VALID), 32'd1);
            check_eq("hold_word", 32'({OUT_SOF, OUT_EOF, OUT_DATA}), 32'(prev_word));
        end
        if (OUT_VALID && OUT_READY) begin
            check_eq("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check_eq("word", 32'({OUT_SOF, OUT_EOF, OUT_DATA}), 32'(exp_q.pop_front()));
        end
        prev_stall = OUT_VALID && !OUT_READY;
        prev_word  = {OUT_SOF, OUT_EOF, OUT_DATA};
    end

    initial begin
        RESET = 1'b1; SAMPLE_STB = 1'b0; OUT_READY = 1'b1; CH_MASK = 16'h0000;
        CH_DATA = 256'd0;
        set_data(16'h1000);
        repeat (3) @(posedge CLK_20M);
        #1 RESET = 1'b0;
        @(negedge CLK_20M);
        check_eq("rst_valid", 32'(OUT_VALID), 32'd0);
        check_eq("rst_data", 32'(OUT_DATA), 32'd0);
        check_eq("rst_sof", 32'(OUT_SOF), 32'd0);
        check_eq("rst_eof", 32'(OUT_EOF), 32'd0);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_drop", 32'(DROP_CNT), 32'd0);

        // Full mask, 18 words with no bubbles.
        CH_MASK = 16'hFFFF;
        push_frame(16'hFFFF, 16'h1000, exp_seq);
        do_strobe();
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK_20M);
            check_eq("t1_nobubble", 32'(OUT_VALID), 32'd1);
        end
        @(negedge CLK_20M);
        check_eq("t1_end_valid", 32'(OUT_VALID), 32'd0);
        check_eq("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_seq++;

        // Sparse mask.
        CH_MASK = 16'h8001;
        push_frame(16'h8001, 16'h1000, exp_seq);
        do_strobe();
        drain(1'b0);
        exp_seq++;

        // Backpressure.
        set_data(16'h4000);
        CH_MASK = 16'hFFFF;
        push_frame(16'hFFFF, 16'h4000, exp_seq);
        do_strobe();
        drain(1'b1);
        exp_seq++;

        // Drop at word 3, then back-to-back strobe on the EOF transfer.
        set_data(16'h2000);
        CH_MASK = 16'hFFFF;
        push_frame(16'hFFFF, 16'h2000, exp_seq);
        do_strobe();
        check_eq("t4_busy", 32'(BUSY), 32'd1);
        repeat (3) @(posedge CLK_20M);
        #1 SAMPLE_STB = 1'b1;
        @(posedge CLK_20M); #1 SAMPLE_STB = 1'b0;
        set_data(16'h3000);
        CH_MASK = 16'h00F0;
        push_frame(16'h00F0, 16'h3000, exp_seq + 16'd1);
        repeat (13) @(posedge CLK_20M);
        #1 SAMPLE_STB = 1'b1;
        @(posedge CLK_20M); #1 SAMPLE_STB = 1'b0;
        @(negedge CLK_20M);
        check_eq("t4_b2b_hdr", 32'({OUT_VALID, OUT_SOF}), 32'd3);
        check_eq("t4_drop", 32'(DROP_CNT), 32'd1);
        drain(1'b0);
        check_eq("t4_idle", 32'(BUSY), 32'd0);
        exp_seq = exp_seq + 16'd2;

        // Empty mask.
        CH_MASK = 16'h0000;
        push_frame(16'h0000, 16'h0000, exp_seq);
        do_strobe();
        drain(1'b0);
        exp_seq++;

        // Reset at word 5 of a full frame.
        set_data(16'h5000);
        CH_MASK = 16'hFFFF;
        push_frame(16'hFFFF, 16'h5000, exp_seq);
        do_strobe();
        repeat (5) @(posedge CLK_20M);
        #1 RESET = 1'b1;
        @(posedge CLK_20M); #1 RESET = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_20M);
            check_eq("t5_abort_valid", 32'(OUT_VALID), 32'd0);
        end
        check_eq("t5_abort_busy", 32'(BUSY), 32'd0);
        check_eq("t5_abort_drop", 32'(DROP_CNT), 32'd0);
        exp_seq = 16'h0000;
        set_data(16'h6000);
        CH_MASK = 16'h0001;
        push_frame(16'h0001, 16'h6000, exp_seq);
        do_strobe();
        drain(1'b0);
        exp_seq++;

`ifdef PACKER_CHECKSUM_EN
        // Checksum trailer with a known constant.
        @(posedge CLK_20M); #1 RESET = 1'b1;
        @(posedge CLK_20M); #1 RESET = 1'b0;
        exp_seq = 16'h0000;
        set_data(16'h0001);
        CH_MASK = 16'h0003;
        exp_q.push_back({2'b10, 16'hA5A5});
        exp_q.push_back({2'b00, 16'h0000});
        exp_q.push_back({2'b00, 16'h0001});
        exp_q.push_back({2'b00, 16'h0002});
        exp_q.push_back({2'b01, 16'hA5A6});
        do_strobe();
        drain(1'b0);
`endif

        repeat (2) @(negedge CLK_20M);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
